// File: rtl/controller.sv
// Ifmap-buffer release controller: counts rising edges of `complete` and pulses
// `free_ifmap_buffer` once every PASSES events. Optional checkers: CONTROLLER_ASSERT_EN.
//
// state   | meaning
// IDLE    | pass_cnt == 0, free_ifmap_buffer low
// ACCUM   | 0 < pass_cnt < PASSES, waiting for remaining passes
// RELEASE | free_ifmap_buffer high for one cycle, pass_cnt already back at 0
module controller #(
  parameter int PASSES = 1,
  parameter int CNT_W  = ($clog2(PASSES + 1) < 1) ? 1 : $clog2(PASSES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic complete,
  output logic free_ifmap_buffer
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PASSES - 1);

  logic             complete_q;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] pass_cnt_d;
  logic             free_d;
  logic             pass_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      complete_q        <= 1'b0;
      pass_cnt          <= '0;
      free_ifmap_buffer <= 1'b0;
    end else begin
      complete_q        <= complete;
      pass_cnt          <= pass_cnt_d;
      free_ifmap_buffer <= free_d;
    end
  end

  // An event landing during RELEASE can only come from a glitch; drop it.
  always_comb begin
    pass_event = complete & ~complete_q & ~free_ifmap_buffer;
    pass_cnt_d = pass_cnt;
    free_d     = 1'b0;
    if (pass_event) begin
      if (pass_cnt == LAST_CNT) begin
        pass_cnt_d = '0;
        free_d     = 1'b1;
      end else begin
        pass_cnt_d = pass_cnt + CNT_W'(1);
      end
    end
  end

`ifdef CONTROLLER_ASSERT_EN
  if (PASSES < 1) begin : g_bad_passes
    $error("controller: PASSES must be at least 1");
  end

  a_single_cycle_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    free_ifmap_buffer |=> !free_ifmap_buffer);

  a_no_unknown : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({free_ifmap_buffer, pass_cnt}));

  a_cnt_in_range : assert property (@(posedge clk)
    32'(pass_cnt) < PASSES);
`else
`endif

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: one instance with PASSES=1 and one with PASSES=3,
// sharing a 20 ns clock; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_controller;

  logic clk = 1'b0;
  logic rst_n1, rst_n3;
  logic complete1, complete3;
  logic free1, free3;

  int tests_run = 0;
  int tests_failed = 0;

  always #10 clk = ~clk;

  controller #(.PASSES(1)) u_dut1 (
    .clk               (clk),
    .rst_n             (rst_n1),
    .complete          (complete1),
    .free_ifmap_buffer (free1)
  );

  controller #(.PASSES(3)) u_dut3 (
    .clk               (clk),
    .rst_n             (rst_n3),
    .complete          (complete3),
    .free_ifmap_buffer (free3)
  );

  task automatic check_bit(input string tag, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on the PASSES=3 instance, then idle so pulses are 4 cycles apart.
  task automatic pulse3(input string tag, input logic exp_release);
    complete3 = 1'b1;
    step();
    check_bit({tag, "_hi"}, free3, exp_release);
    complete3 = 1'b0;
    step();
    check_bit({tag, "_lo"}, free3, 1'b0);
    step();
    check_bit({tag, "_gap1"}, free3, 1'b0);
    step();
    check_bit({tag, "_gap2"}, free3, 1'b0);
  endtask

  initial begin
    rst_n1 = 1'b0;
    rst_n3 = 1'b0;
    complete1 = 1'b0;
    complete3 = 1'b0;

    #1;
    check_bit("reset_async_p1", free1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_bit("reset_hold_p1", free1, 1'b0);
      check_bit("reset_hold_p3", free3, 1'b0);
    end
    rst_n1 = 1'b1;
    rst_n3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_bit("post_reset_p1", free1, 1'b0);
      check_bit("post_reset_p3", free3, 1'b0);
    end

    // PASSES=1 single pulse
    complete1 = 1'b1;
    step();
    check_bit("p1_single_hi", free1, 1'b1);
    complete1 = 1'b0;
    step();
    check_bit("p1_single_lo", free1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_bit("p1_single_after", free1, 1'b0);
    end

    // PASSES=1 level held for 6 cycles: one release only
    complete1 = 1'b1;
    step();
    check_bit("p1_held_first", free1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_bit("p1_held_rest", free1, 1'b0);
    end
    complete1 = 1'b0;
    step();
    check_bit("p1_held_drop", free1, 1'b0);
    step();

    // PASSES=1 back-to-back toggling: releases 2 cycles apart
    complete1 = 1'b1;
    step();
    check_bit("p1_b2b_rel1", free1, 1'b1);
    complete1 = 1'b0;
    step();
    check_bit("p1_b2b_gap", free1, 1'b0);
    complete1 = 1'b1;
    step();
    check_bit("p1_b2b_rel2", free1, 1'b1);
    complete1 = 1'b0;
    step();
    check_bit("p1_b2b_end", free1, 1'b0);
    step();
    check_bit("p1_b2b_idle", free1, 1'b0);

    // complete already high when reset deasserts counts as an event
    rst_n1 = 1'b0;
    complete1 = 1'b1;
    step();
    check_bit("p1_rst_hold_high", free1, 1'b0);
    rst_n1 = 1'b1;
    step();
    check_bit("p1_rst_release_event", free1, 1'b1);
    complete1 = 1'b0;
    step();
    check_bit("p1_rst_release_lo", free1, 1'b0);

    // PASSES=3: two silent passes, release on the third, then again
    pulse3("p3_a1", 1'b0);
    pulse3("p3_a2", 1'b0);
    pulse3("p3_a3", 1'b1);
    pulse3("p3_b1", 1'b0);
    pulse3("p3_b2", 1'b0);
    pulse3("p3_b3", 1'b1);

    // Reset mid-accumulation discards the partial count
    pulse3("p3_r1", 1'b0);
    pulse3("p3_r2", 1'b0);
    #5;
    rst_n3 = 1'b0;
    #1;
    check_bit("p3_mid_reset", free3, 1'b0);
    step();
    rst_n3 = 1'b1;
    step();
    check_bit("p3_after_reset", free3, 1'b0);
    pulse3("p3_post1", 1'b0);
    pulse3("p3_post2", 1'b0);
    pulse3("p3_post3", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
